// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS main control unit.
package mips_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation select
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] ALU_SRC_B_REG    = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // FSM states; the encoding is visible on state_dbg, so it is pinned explicitly
  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  // Datapath control word driven for each state
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational map from FSM state (and mem_ready in FETCH) to the datapath control word.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic       mem_ready,
  output ctrl_word_t ctrl
);

  // Every field defaults to 0; each state raises only what it needs
  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      StDecode: begin
        ctrl.alu_src_b = ALU_SRC_B_IMM_SH;
      end
      StMemAdr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      StAluWb: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALU_SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
      end
      StAddiWb: begin
        ctrl.reg_write = 1'b1;
      end
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS main control: state register, next-state logic and retire counter.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter bit          ENABLE_ADDI  = 1'b1,
  parameter bit          ENABLE_JUMP  = 1'b1,
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              instr_op,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic                    mem_to_reg,
  output logic                    reg_dst,
  output logic                    reg_write,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [1:0]              pc_source,
  output logic                    illegal_op,
  output logic [3:0]              state_dbg,
  output logic [RETIRE_CNT_W-1:0] retired_cnt
);

  state_e                  state_q, state_d;
  logic [RETIRE_CNT_W-1:0] retired_cnt_q;
  logic                    retire;
  logic                    illegal;
  ctrl_word_t              ctrl;

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Next state, retire strobe (edge leaving the final state) and illegal-opcode detect
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    illegal = 1'b0;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (instr_op)
          OP_RTYPE:     state_d = StExec;
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_BEQ:       state_d = StBranch;
          OP_ADDI: begin
            if (ENABLE_ADDI) state_d = StAddiEx;
            else begin
              state_d = StFetch;
              illegal = 1'b1;
            end
          end
          OP_J: begin
            if (ENABLE_JUMP) state_d = StJump;
            else begin
              state_d = StFetch;
              illegal = 1'b1;
            end
          end
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      // Only lw/sw reach here; IR is stable so the opcode picks the access direction
      StMemAdr: state_d = (instr_op == OP_SW) ? StMemWr : StMemRd;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StAluWb, StBranch, StAddiWb, StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default:  state_d = StFetch;
    endcase
  end

  // State register and retire counter; reset aborts any in-flight instruction uncounted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StFetch;
      retired_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_cnt_q <= retired_cnt_q + RETIRE_CNT_W'(1);
    end
  end

  // Outputs: enables and the illegal pulse are squashed while reset is held
  always_comb begin
    pc_write      = ctrl.pc_write      & ~rst;
    pc_write_cond = ctrl.pc_write_cond & ~rst;
    mem_read      = ctrl.mem_read      & ~rst;
    mem_write     = ctrl.mem_write     & ~rst;
    ir_write      = ctrl.ir_write      & ~rst;
    reg_write     = ctrl.reg_write     & ~rst;
    illegal_op    = illegal            & ~rst;
    i_or_d        = ctrl.i_or_d;
    mem_to_reg    = ctrl.mem_to_reg;
    reg_dst       = ctrl.reg_dst;
    alu_src_a     = ctrl.alu_src_a;
    alu_src_b     = ctrl.alu_src_b;
    alu_op        = ctrl.alu_op;
    pc_source     = ctrl.pc_source;
    state_dbg     = state_q;
    retired_cnt   = retired_cnt_q;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: default build, jump-disabled build and
// a 2-bit retire counter build all share the same stimulus.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] instr_op = 6'd0;
  logic       mem_ready = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  // Default instance
  logic a_pc_write, a_pc_write_cond, a_i_or_d, a_mem_read, a_mem_write, a_ir_write;
  logic a_mem_to_reg, a_reg_dst, a_reg_write, a_alu_src_a, a_illegal_op;
  logic [1:0]  a_alu_src_b, a_alu_op, a_pc_source;
  logic [3:0]  a_state;
  logic [31:0] a_cnt;

  // ENABLE_JUMP = 0 instance
  logic n_pc_write, n_pc_write_cond, n_i_or_d, n_mem_read, n_mem_write, n_ir_write;
  logic n_mem_to_reg, n_reg_dst, n_reg_write, n_alu_src_a, n_illegal_op;
  logic [1:0]  n_alu_src_b, n_alu_op, n_pc_source;
  logic [3:0]  n_state;
  logic [31:0] n_cnt;

  // RETIRE_CNT_W = 2 instance
  logic w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
  logic w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a, w_illegal_op;
  logic [1:0] w_alu_src_b, w_alu_op, w_pc_source;
  logic [3:0] w_state;
  logic [1:0] w_cnt;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
    .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond), .i_or_d(a_i_or_d),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .ir_write(a_ir_write),
    .mem_to_reg(a_mem_to_reg), .reg_dst(a_reg_dst), .reg_write(a_reg_write),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
    .pc_source(a_pc_source), .illegal_op(a_illegal_op), .state_dbg(a_state),
    .retired_cnt(a_cnt)
  );

  multicycle_control_unit #(.ENABLE_JUMP(1'b0)) dut_nj (
    .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
    .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .i_or_d(n_i_or_d),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
    .mem_to_reg(n_mem_to_reg), .reg_dst(n_reg_dst), .reg_write(n_reg_write),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
    .pc_source(n_pc_source), .illegal_op(n_illegal_op), .state_dbg(n_state),
    .retired_cnt(n_cnt)
  );

  multicycle_control_unit #(.RETIRE_CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
    .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .i_or_d(w_i_or_d),
    .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write),
    .mem_to_reg(w_mem_to_reg), .reg_dst(w_reg_dst), .reg_write(w_reg_write),
    .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op),
    .pc_source(w_pc_source), .illegal_op(w_illegal_op), .state_dbg(w_state),
    .retired_cnt(w_cnt)
  );

  always #5 clk = ~clk;

  // Advance one cycle: drive inputs on the falling edge, let outputs settle, return
  task automatic drive(input logic r, input logic [5:0] op, input logic rdy);
    @(negedge clk);
    rst       = r;
    instr_op  = op;
    mem_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 6'b000000, 1'b1);
      n_cmp++;
      if (a_state !== 4'd0) begin
        n_err++; $display("FAIL reset_state: got %0d want 0", a_state);
      end
      n_cmp++;
      if ({a_pc_write, a_pc_write_cond, a_mem_read, a_mem_write, a_ir_write, a_reg_write,
           a_illegal_op} !== 7'b0) begin
        n_err++; $display("FAIL reset_enables: got %b want 0", {a_pc_write, a_pc_write_cond,
                          a_mem_read, a_mem_write, a_ir_write, a_reg_write, a_illegal_op});
      end
      n_cmp++;
      if (a_cnt !== 32'd0 || w_cnt !== 2'd0) begin
        n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", a_cnt, w_cnt);
      end
    end
  endtask

  task automatic test_rtype();
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 6'b000000, 1'b1);
      n_cmp++;
      if (a_state !== exp_st[i]) begin
        n_err++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, a_state, exp_st[i]);
      end
      n_cmp++;
      if (a_reg_write !== (i == 3) || a_reg_dst !== (i == 3)) begin
        n_err++; $display("FAIL rtype_wb[%0d]: got rw=%b rd=%b want %b", i, a_reg_write,
                          a_reg_dst, (i == 3));
      end
    end
    drive(1'b0, 6'b000000, 1'b0);
    n_cmp++;
    if (a_state !== 4'd0 || a_cnt !== 32'd1) begin
      n_err++; $display("FAIL rtype_retire: got st=%0d cnt=%0d want 0/1", a_state, a_cnt);
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    logic       rdy    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 6'b100011, rdy[i]);
      n_cmp++;
      if (a_state !== exp_st[i]) begin
        n_err++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, a_state, exp_st[i]);
      end
      if (exp_st[i] == 4'd3) begin
        n_cmp++;
        if (a_mem_read !== 1'b1 || a_i_or_d !== 1'b1) begin
          n_err++; $display("FAIL lw_memrd[%0d]: got rd=%b iod=%b want 1/1", i, a_mem_read,
                            a_i_or_d);
        end
      end
      if (exp_st[i] == 4'd4) begin
        n_cmp++;
        if (a_mem_to_reg !== 1'b1 || a_reg_write !== 1'b1 || a_reg_dst !== 1'b0) begin
          n_err++; $display("FAIL lw_memwb: got m2r=%b rw=%b rd=%b want 1/1/0", a_mem_to_reg,
                            a_reg_write, a_reg_dst);
        end
      end
    end
    drive(1'b0, 6'b100011, 1'b0);
    n_cmp++;
    if (a_state !== 4'd0 || a_cnt !== 32'd2) begin
      n_err++; $display("FAIL lw_retire: got st=%0d cnt=%0d want 0/2", a_state, a_cnt);
    end
  endtask

  task automatic test_sw_beq();
    logic [3:0] sw_st [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    logic [3:0] bq_st [3] = '{4'd0, 4'd1, 4'd8};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 6'b101011, 1'b1);
      n_cmp++;
      if (a_state !== sw_st[i] || a_mem_write !== (i == 3) || a_reg_write !== 1'b0) begin
        n_err++; $display("FAIL sw[%0d]: got st=%0d mw=%b rw=%b want %0d/%b/0", i, a_state,
                          a_mem_write, a_reg_write, sw_st[i], (i == 3));
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 6'b000100, 1'b1);
      n_cmp++;
      if (a_state !== bq_st[i] || a_pc_write_cond !== (i == 2)) begin
        n_err++; $display("FAIL beq[%0d]: got st=%0d pwc=%b want %0d/%b", i, a_state,
                          a_pc_write_cond, bq_st[i], (i == 2));
      end
    end
    n_cmp++;
    if (a_alu_op !== 2'b01 || a_pc_source !== 2'b01 || a_alu_src_a !== 1'b1 ||
        a_alu_src_b !== 2'b00) begin
      n_err++; $display("FAIL beq_ctrl: got op=%b ps=%b sa=%b sb=%b want 01/01/1/00", a_alu_op,
                        a_pc_source, a_alu_src_a, a_alu_src_b);
    end
    drive(1'b0, 6'b000000, 1'b0);
    n_cmp++;
    if (a_state !== 4'd0 || a_cnt !== 32'd4) begin
      n_err++; $display("FAIL beq_retire: got st=%0d cnt=%0d want 0/4", a_state, a_cnt);
    end
  endtask

  task automatic test_illegal();
    drive(1'b0, 6'b111111, 1'b1);
    drive(1'b0, 6'b111111, 1'b1);
    n_cmp++;
    if (a_state !== 4'd1 || a_illegal_op !== 1'b1) begin
      n_err++; $display("FAIL illegal_pulse: got st=%0d ill=%b want 1/1", a_state, a_illegal_op);
    end
    drive(1'b0, 6'b111111, 1'b0);
    n_cmp++;
    if (a_state !== 4'd0 || a_illegal_op !== 1'b0 || a_cnt !== 32'd4) begin
      n_err++; $display("FAIL illegal_after: got st=%0d ill=%b cnt=%0d want 0/0/4", a_state,
                        a_illegal_op, a_cnt);
    end
  endtask

  task automatic test_jump();
    drive(1'b0, 6'b000010, 1'b1);
    drive(1'b0, 6'b000010, 1'b1);
    n_cmp++;
    if (n_state !== 4'd1 || n_illegal_op !== 1'b1 || a_illegal_op !== 1'b0) begin
      n_err++; $display("FAIL jump_decode: got nj_st=%0d nj_ill=%b ill=%b want 1/1/0", n_state,
                        n_illegal_op, a_illegal_op);
    end
    // Hold mem_ready low so the disabled build idles in FETCH while the other jumps
    drive(1'b0, 6'b000010, 1'b0);
    n_cmp++;
    if (a_state !== 4'd11 || a_pc_write !== 1'b1 || a_pc_source !== 2'b10) begin
      n_err++; $display("FAIL jump_exec: got st=%0d pw=%b ps=%b want 11/1/10", a_state,
                        a_pc_write, a_pc_source);
    end
    n_cmp++;
    if (n_state !== 4'd0 || n_illegal_op !== 1'b0 || n_pc_write !== 1'b0) begin
      n_err++; $display("FAIL jump_disabled: got st=%0d ill=%b pw=%b want 0/0/0", n_state,
                        n_illegal_op, n_pc_write);
    end
    drive(1'b0, 6'b000000, 1'b0);
    n_cmp++;
    if (a_state !== 4'd0 || a_cnt !== 32'd5 || n_cnt !== 32'd4) begin
      n_err++; $display("FAIL jump_retire: got st=%0d cnt=%0d nj_cnt=%0d want 0/5/4", a_state,
                        a_cnt, n_cnt);
    end
  endtask

  task automatic test_reset_midop();
    drive(1'b0, 6'b101011, 1'b1);
    drive(1'b0, 6'b101011, 1'b1);
    drive(1'b0, 6'b101011, 1'b1);
    drive(1'b0, 6'b101011, 1'b0);
    n_cmp++;
    if (a_state !== 4'd5 || a_mem_write !== 1'b1) begin
      n_err++; $display("FAIL midop_memwr: got st=%0d mw=%b want 5/1", a_state, a_mem_write);
    end
    drive(1'b1, 6'b101011, 1'b0);
    n_cmp++;
    if (a_state !== 4'd5 || a_mem_write !== 1'b0 || a_i_or_d !== 1'b1) begin
      n_err++; $display("FAIL midop_squash: got st=%0d mw=%b iod=%b want 5/0/1", a_state,
                        a_mem_write, a_i_or_d);
    end
    drive(1'b0, 6'b001000, 1'b0);
    n_cmp++;
    if (a_state !== 4'd0 || a_cnt !== 32'd0 || w_cnt !== 2'd0 || n_state !== 4'd0) begin
      n_err++; $display("FAIL midop_reset: got st=%0d cnt=%0d w_cnt=%0d nj_st=%0d want 0/0/0/0",
                        a_state, a_cnt, w_cnt, n_state);
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [1:0] exp_w [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd9, 4'd10};
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, 6'b001000, 1'b1);
        if (k == 0) begin
          n_cmp++;
          if (w_state !== exp_st[i] || w_reg_write !== (i == 3)) begin
            n_err++; $display("FAIL addi_state[%0d]: got st=%0d rw=%b want %0d/%b", i, w_state,
                              w_reg_write, exp_st[i], (i == 3));
          end
        end
      end
      // Sample the FETCH cycle that follows ADDI_WB without consuming an instruction
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if (w_cnt !== exp_w[k] || a_cnt !== 32'(k + 1)) begin
        n_err++; $display("FAIL wrap[%0d]: got w=%0d a=%0d want %0d/%0d", k, w_cnt, a_cnt,
                          exp_w[k], k + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw_beq();
    test_illegal();
    test_jump();
    test_reset_midop();
    test_back_to_back_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle MIPS main control: a Moore-style FSM that sequences fetch, decode, execute, memory and write-back over several cycles per instruction. It drives the shared-memory/shared-ALU multi-cycle datapath and stalls on a memory-ready handshake. It supports R-type, lw, sw, beq, addi and j (addi and j can be disabled), flags illegal opcodes, and counts retired instructions.

Parameters:
ENABLE_ADDI, 1, 1 = opcode 001000 decoded as addi; 0 = treated as illegal
ENABLE_JUMP, 1, 1 = opcode 000010 decoded as j; 0 = treated as illegal
RETIRE_CNT_W, 32, width of the retired-instruction counter (2..64)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous active-high reset
instr_op  in  6  opcode from the instruction register (IR[31:26])
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = MDR
reg_dst  out  1  destination: 0 = rt, 1 = rd
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  out  1  one-cycle pulse on an undecodable opcode in DECODE
state_dbg  out  4  current state encoding
retired_cnt  out  RETIRE_CNT_W  instructions completed, wraps modulo 2^RETIRE_CNT_W

Behaviour:
- States: FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, BRANCH, ADDI_EX, ADDI_WB, JUMP.
- Reset: on the rising edge with rst=1, state <= FETCH and retired_cnt <= 0. While rst=1, every enable (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) is forced to 0 and illegal_op is forced to 0. Reset mid-instruction aborts the instruction with no retire count.
- Any signal not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write are 1 only when mem_ready=1; the FSM then goes to DECODE. Otherwise it stays in FETCH with both deasserted.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - 000000 -> EXEC; 100011 or 101011 -> MEM_ADR; 000100 -> BRANCH.
  - 001000 -> ADDI_EX when ENABLE_ADDI; 000010 -> JUMP when ENABLE_JUMP.
  - Any other opcode: illegal_op=1 for this cycle, then FETCH (the instruction is a no-op and is not counted).
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Goes to MEM_WB when mem_ready=1, otherwise holds.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1; then FETCH; retire.
- MEM_WR: mem_write=1, i_or_d=1. Goes to FETCH and retires when mem_ready=1; otherwise holds with mem_write held at 1.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then ALU_WB.
- ALU_WB: reg_dst=1, mem_to_reg=0, reg_write=1; then FETCH; retire.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; then FETCH; retire.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1; then FETCH; retire.
- JUMP: pc_write=1, pc_source=10; then FETCH; retire.
- retire: retired_cnt increments by 1 on the edge leaving the final state. It wraps from all-ones to 0.
- Latency with mem_ready tied to 1:
  - R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - addi: 4 cycles.
  - j: 3 cycles.
  - Each cycle mem_ready is low adds one cycle in FETCH/MEM_RD/MEM_WR.
- Outputs are combinational from state (plus mem_ready gating in FETCH) and are never X.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - the state enum with 4-bit encoding (FETCH = 0);
  - ALU_OP codes;
  - ALU_SRC_B codes;
  - PC_SRC codes.
- One sub-module, mc_ctrl_decode: a purely combinational state+mem_ready -> control-word map, so the FSM module holds only the state register, next-state logic and counter.

Test Plan:
- Reset and R-type: rst=1 for 2 cycles, then instr_op=000000 with mem_ready=1 -> states FETCH, DECODE, EXEC, ALU_WB, FETCH. reg_write=1 and reg_dst=1 only in ALU_WB; retired_cnt=1.
- lw with stall: instr_op=100011, mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1 and i_or_d=1. MEM_WB has mem_to_reg=1; 8 total cycles.
- sw and beq: 101011 -> mem_write=1 only in MEM_WR and no reg_write ever. 000100 -> BRANCH with pc_write_cond=1, alu_op=01, pc_source=01; 3 cycles.
- Parameter disable: ENABLE_JUMP=0, instr_op=000010 -> illegal_op pulses 1 cycle in DECODE, then FETCH; retired_cnt unchanged. With ENABLE_JUMP=1, JUMP has pc_write=1 and pc_source=10.
- Reset mid-op: assert rst in MEM_WR while mem_ready=0 -> mem_write=0 in that cycle; state=FETCH and retired_cnt=0 next cycle.
- Counter wrap: RETIRE_CNT_W=2, run 5 addi instructions -> retired_cnt sequence 1, 2, 3, 0, 1.
